// File: rtl/pulse_stretch.sv
// pulse_stretch: rebuilds single-cycle events into L-cycle level pulses with a forced low gap.
module pulse_stretch #(
  parameter int LEN_W  = 8,
  parameter int GAP    = 2,
  parameter int RETRIG = 1,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic [LEN_W-1:0]  len,
  output logic              level_out,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [GW-1:0] GCNT_LD = GW'(GAP - 1);
  typedef enum logic [1:0] {IDLE, STRETCH, HOLD} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_ld;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic pend_q, pend_d, level_q, level_d, busy_q, busy_d, q_ev;
  logic [DROP_W-1:0] drop_q, drop_d;
  assign cnt_ld = (len == '0) ? '0 : len - LEN_W'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    pend_d  = pend_q;
    level_d = level_q;
    drop_d  = drop_q;
    q_ev    = 1'b0;
    case (state_q)
      IDLE:
        if (pulse_in) begin
          state_d = STRETCH;
          level_d = 1'b1;
          cnt_d   = cnt_ld;
        end
      STRETCH:
        if (RETRIG != 0 && pulse_in) cnt_d = cnt_ld;
        else begin
          q_ev = pulse_in;
          if (cnt_q == '0) begin
            state_d = HOLD;
            level_d = 1'b0;
            gcnt_d  = GCNT_LD;
          end else cnt_d = cnt_q - LEN_W'(1);
        end
      HOLD:
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GW'(1);
          q_ev   = pulse_in;
        end else if (pend_q || pulse_in) begin
          // a queued event and a fresh one together: start one, keep one queued
          state_d = STRETCH;
          level_d = 1'b1;
          cnt_d   = cnt_ld;
          pend_d  = pend_q & pulse_in;
        end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (q_ev) begin
      if (!pend_q) pend_d = 1'b1;
      else if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      pend_q  <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      pend_q  <= pend_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end
  assign level_out = level_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: runs a queueing (RETRIG=0) and a retriggering (RETRIG=1) instance side by side
// against a timeline model built from start edge, fall edge and gap end.
module tb_pulse_stretch;
  localparam int LEN_W = 8, GAP = 2, DROP_W = 8;
  localparam int DMAX = (1 << DROP_W) - 1;
  logic clk = 1'b0, rst = 1'b1, pulse_in = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [1:0] lvl, bsy;
  logic [DROP_W-1:0] drp0, drp1;
  int tests = 0, fails = 0, e = 0;
  int m_fall[2], m_drop[2];
  bit m_act[2], m_pend[2];
  pulse_stretch #(.LEN_W(LEN_W), .GAP(GAP), .RETRIG(0), .DROP_W(DROP_W)) u0 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .len(len),
    .level_out(lvl[0]), .busy(bsy[0]), .drop_cnt(drp0));
  pulse_stretch #(.LEN_W(LEN_W), .GAP(GAP), .RETRIG(1), .DROP_W(DROP_W)) u1 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .len(len),
    .level_out(lvl[1]), .busy(bsy[1]), .drop_cnt(drp1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, e, obs, want);
    end
  endtask
  function automatic void enqueue(input int m);
    if (!m_pend[m]) m_pend[m] = 1'b1;
    else if (m_drop[m] < DMAX) m_drop[m]++;
  endfunction
  // fall = edge at which level drops; the gap ends GAP edges later
  function automatic void model(input int m, input bit r, input bit p, input int l);
    int le = (l == 0) ? 1 : l;
    if (r) begin
      m_act[m] = 1'b0;
      m_pend[m] = 1'b0;
      m_drop[m] = 0;
    end else if (!m_act[m] || e > m_fall[m] + GAP) begin
      if (p) begin
        m_act[m] = 1'b1;
        m_fall[m] = e + le;
      end
    end else if (e <= m_fall[m]) begin
      if (m == 1 && p) m_fall[m] = e + le;
      else if (p) enqueue(m);
    end else if (e < m_fall[m] + GAP) begin
      if (p) enqueue(m);
    end else if (m_pend[m] || p) begin
      m_fall[m] = e + le;
      m_pend[m] = m_pend[m] && p;
    end
  endfunction
  task automatic step(input bit r, input bit p, input int l);
    @(negedge clk);
    rst = r;
    pulse_in = p;
    len = l[LEN_W-1:0];
    @(posedge clk);
    e++;
    for (int m = 0; m < 2; m++) model(m, r, p, l);
    #1;
    chk("level_q", lvl[0], m_act[0] && e < m_fall[0]);
    chk("busy_q", bsy[0], m_act[0] && e < m_fall[0] + GAP);
    chk("drop_q", drp0, m_drop[0]);
    chk("level_r", lvl[1], m_act[1] && e < m_fall[1]);
    chk("busy_r", bsy[1], m_act[1] && e < m_fall[1] + GAP);
    chk("drop_r", drp1, m_drop[1]);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4);
    chk("reset_level", lvl, 0);
    chk("reset_busy", bsy, 0);
    chk("reset_drop", drp0, 0);
    while (e < 9) step(1'b0, 1'b0, 4);
    step(1'b0, 1'b1, 4);
    chk("single_rise", lvl[0], 1);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 4);
      chk("single_level", lvl[0], i < 4);
      chk("single_busy", bsy[0], i < 6);
    end
    chk("single_drop", drp0, 0);
    step(1'b0, 1'b1, 0);
    chk("zero_rise", lvl[0], 1);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 1'b0, 0);
      chk("zero_level", lvl[0], 0);
      chk("zero_busy", bsy[0], i < 3);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, i == 0 || i == 3, 5);
      chk("retrig_level", lvl[1], i < 8);
    end
    chk("retrig_drop", drp1, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, i < 3, 3);
      chk("queue_level", lvl[0], i < 3 || (i >= 5 && i < 8));
    end
    chk("queue_drop", drp0, 1);
    chk("queue_idle", bsy[0], 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
    step(1'b1, 1'b0, 3);
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1, 3);
    chk("sat_drop", drp0, DMAX);
    chk("sat_retrig_drop", drp1, 0);
    step(1'b1, 1'b0, 10);
    step(1'b0, 1'b1, 10);
    step(1'b0, 1'b0, 10);
    step(1'b0, 1'b0, 10);
    chk("pre_reset_level", lvl[0], 1);
    step(1'b1, 1'b0, 10);
    chk("trunc_level", lvl, 0);
    chk("trunc_busy", bsy, 0);
    chk("trunc_drop", drp0, 0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 10);
      chk("post_reset_idle", bsy, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Receive-side companion to `pulse_gen`. It takes the single-cycle pulses produced by an edge detector and rebuilds them into level pulses of a programmable length. A guaranteed low gap separates consecutive output pulses, so downstream logic on slower or sampled domains can see every event. Events that arrive while the block is busy are retriggered, queued one deep, or counted as dropped, depending on the mode.

## Interface
Parameters:
- `LEN_W`, 8: width of `len`.
- `GAP`, 2: number of low cycles forced between output pulses. Legal range is ≥ 1.
- `RETRIG`, 1: 1 = a pulse during an active stretch restarts it; 0 = the pulse is queued or dropped.
- `DROP_W`, 8: width of the saturating drop counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pulse_in` in 1: event input. Each cycle it is high counts as one event.
- `len` in LEN_W: stretch length in cycles, sampled at the edge that starts or restarts a stretch. A value of 0 is treated as 1.
- `level_out` out 1: stretched output, registered.
- `busy` out 1: high whenever state ≠ IDLE, registered.
- `drop_cnt` out DROP_W: number of events lost. Saturates at all-ones, registered.

## Operation
- States: IDLE, STRETCH, HOLD (the forced gap).
- Internal registers:
  - `cnt`: LEN_W bits, stretch countdown.
  - `gcnt`: ⌈log2(GAP+1)⌉ bits, gap countdown.
  - `pend`: 1 bit, a single queued event.
- Definition used below: `L = (len==0) ? 1 : len`.
- IDLE:
  - `pulse_in` = 1 → go to STRETCH; `level_out` ← 1; `cnt` ← L−1.
- STRETCH, rules in priority order:
  1. `RETRIG` = 1 and `pulse_in` = 1 → `cnt` ← L−1 (uses the current `len`); stay in STRETCH.
  2. `RETRIG` = 0 and `pulse_in` = 1 → queue rule (below). The countdown continues in the same cycle.
  3. `cnt` = 0 → go to HOLD; `level_out` ← 0; `gcnt` ← GAP−1.
  4. Otherwise `cnt` ← `cnt`−1.
- HOLD:
  - If `gcnt` ≠ 0: `gcnt` decrements, and `pulse_in` follows the queue rule.
  - If `gcnt` = 0 and (`pend` | `pulse_in`): go to STRETCH; `level_out` ← 1; `cnt` ← L−1; `pend` ← `pend` & `pulse_in`. If both were set, one event starts now and the other stays queued.
  - If `gcnt` = 0 and neither is set: go to IDLE.
- Queue rule:
  - `pend` = 0 → `pend` ← 1.
  - `pend` = 1 → `drop_cnt` ← `drop_cnt`+1, unless it is already at all-ones, in which case it holds.
- In RETRIG = 1 mode, `pend` can only be set during HOLD.
- Reset:
  - At any edge with `rst` = 1: state ← IDLE; `level_out`, `busy`, `pend`, `cnt`, `gcnt`, `drop_cnt` ← 0.
  - `pulse_in` is ignored while `rst` = 1.
  - A stretch in progress when reset is asserted is truncated, with no HOLD.
- `drop_cnt` clears only on reset.

## Timing
- Latency: `pulse_in` sampled high at edge k → `level_out` high after edge k.
- Pulse length: `level_out` stays high for exactly L cycles after the last start or restart, then falls.
- Gap: `level_out` then stays low for at least GAP cycles before the next rise.
- `busy` rises together with `level_out`. It falls GAP cycles after `level_out` falls if nothing is pending.
- Back-to-back, RETRIG = 0, queued event: the next rise comes exactly GAP cycles after the fall, and the new stretch uses `len` as sampled at that edge.
- `len` changes in the middle of a stretch have no effect until the next start or restart.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single event: `rst` 1→0, then `len`=4 and a `pulse_in` at edge 10 → `level_out` high after edges 10–13, low after 14; `busy` high through edge 15 (GAP=2), low after 16; `drop_cnt`=0.
- Zero length: `len`=0 with a single pulse → `level_out` high for exactly 1 cycle, then a 2-cycle HOLD, then IDLE.
- Retrigger (RETRIG=1): `len`=5, pulses at edges t and t+3 → `level_out` high continuously for 8 cycles; no gap in between; `drop_cnt`=0.
- Queue and drop (RETRIG=0): `len`=3, pulses at t, t+1, t+2 → high 3 cycles, low 2, high 3, then IDLE; `drop_cnt`=1.
- Saturation (RETRIG=0, DROP_W=8): `pulse_in` held high for 2000 cycles → `drop_cnt` stops at 255; the output keeps alternating L high / GAP low.
- Reset mid-stretch: `len`=10, pulse, then `rst`=1 on the 3rd high cycle → all outputs 0 at the next edge; after reset is released with no input, the block stays idle.
